// File: rtl/if_fetch_buf_if.sv
// Fetch-buffer bus: groups the instruction-ROM port and the ID-stage
// valid/ready port of if_fetch_buf into one bundle.
// master = the fetch buffer, slave = the ROM/ID side.
interface if_fetch_buf_if #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 16,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // ROM side
    logic              rom_ce_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [INST_W-1:0] rom_inst_i;

    // ID side
    logic              id_ready_i;
    logic              id_valid_o;
    logic [ADDR_W-1:0] id_pc_o;
    logic [INST_W-1:0] id_inst_o;
    logic [CNT_W-1:0]  count_o;

    modport master (
        output rom_ce_o,
        output rom_addr_o,
        input  rom_inst_i,
        input  id_ready_i,
        output id_valid_o,
        output id_pc_o,
        output id_inst_o,
        output count_o
    );

    modport slave (
        input  rom_ce_o,
        input  rom_addr_o,
        output rom_inst_i,
        output id_ready_i,
        input  id_valid_o,
        input  id_pc_o,
        input  id_inst_o,
        input  count_o
    );
endinterface

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: instruction-fetch front end for mcpu.
// Holds the PC generator, drives the instruction-ROM request and buffers
// fetched {pc, inst} pairs in a DEPTH-entry FIFO that feeds ID through a
// valid/ready handshake. Supports global stall, branch redirect with flush
// and back-pressure from ID.
// Optional feature macro: IF_FETCH_BYPASS_EN -- when defined, a word fetched
// while the FIFO is empty and ID is ready goes straight to ID in the same
// cycle instead of passing through the FIFO.
module if_fetch_buf #(
    parameter int                ADDR_W   = 16,
    parameter int                INST_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1)
) (
    input  logic              clk,
    input  logic              rst,            // asynchronous, active low
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    if_fetch_buf_if.master    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + INST_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    // Architectural state
    logic [ADDR_W-1:0] pc_reg;
    logic [PTR_W-1:0]  rptr_reg;
    logic [PTR_W-1:0]  wptr_reg;
    logic [CNT_W-1:0]  count_reg;

    // FIFO storage: each entry is {pc, inst}; not reset, guarded by count_reg
    logic [ENT_W-1:0]  mem [DEPTH];

    // Per-cycle control
    logic              not_empty;
    logic              can_move;
    logic              fifo_pop;
    logic              fetch;
    logic              bypass;
    logic              fifo_push;
    logic [ENT_W-1:0]  head;

    // Handshake decode: branch beats stall, stall beats everything else
    always_comb begin
        not_empty = (count_reg != '0);
        can_move  = ~stall_i & ~branch_flag_i;
        fifo_pop  = not_empty & bus.id_ready_i & can_move;
        // A full FIFO can still fetch when its head leaves in the same cycle.
        // Gating with rst keeps the ROM idle while reset is held.
        fetch     = rst & can_move & ((count_reg < FULL) | fifo_pop);
`ifdef IF_FETCH_BYPASS_EN
        bypass    = fetch & ~not_empty & bus.id_ready_i;
`else
        bypass    = 1'b0;
`endif
        fifo_push = fetch & ~bypass;
        head      = mem[rptr_reg];
    end

    // Output drive: head of the FIFO, the bypassed ROM word, or zeros
    always_comb begin
        bus.rom_ce_o   = fetch;
        bus.rom_addr_o = pc_reg;
        bus.count_o    = count_reg;
        bus.id_valid_o = not_empty | bypass;
        bus.id_pc_o    = '0;
        bus.id_inst_o  = '0;
        if (not_empty) begin
            bus.id_pc_o   = head[ENT_W-1:INST_W];
            bus.id_inst_o = head[INST_W-1:0];
        end else if (bypass) begin
            bus.id_pc_o   = pc_reg;
            bus.id_inst_o = bus.rom_inst_i;
        end
    end

    // FIFO write port: capture the ROM word together with the PC that fetched it
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem[wptr_reg] <= {pc_reg, bus.rom_inst_i};
        end
    end

    // PC, pointers and occupancy; a redirect empties the FIFO and reloads the PC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg    <= RESET_PC;
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else if (branch_flag_i) begin
            pc_reg    <= branch_addr_i;
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (fetch) begin
                pc_reg <= pc_reg + PC_STEP;
            end
            if (fifo_push) begin
                wptr_reg <= wptr_reg + PTR_W'(1);
            end
            if (fifo_pop) begin
                rptr_reg <= rptr_reg + PTR_W'(1);
            end
            if (fifo_push && !fifo_pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (fifo_pop && !fifo_push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/if_fetch_buf.md
Name: if_fetch_buf

Overview:
Parametrised instruction-fetch front end for mcpu. It replaces the separate pc / if_id pair with a single block holding the PC generator, the instruction-ROM request, and a DEPTH-entry fetch FIFO. The block feeds ID with a valid/ready handshake, and supports stall, branch redirect with flush, and back-pressure. It sits between inst_rom and the ID stage.

Parameters:
ADDR_W, 16, PC / ROM address width
INST_W, 16, instruction width
DEPTH, 4, FIFO entries; power of 2, minimum 2
RESET_PC, 0, PC value loaded on reset
PC_STEP, 1, PC increment per fetched instruction, modulo 2^ADDR_W

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
stall_i  in  1  global pipeline stall
branch_flag_i  in  1  redirect request from ID
branch_addr_i  in  ADDR_W  redirect target
rom_ce_o  out  1  ROM chip enable
rom_addr_o  out  ADDR_W  ROM address; always equals the PC register
rom_inst_i  in  INST_W  ROM data; combinational, valid in the same cycle as rom_addr_o
id_ready_i  in  1  ID accepts the head entry
id_valid_o  out  1  head entry valid
id_pc_o  out  ADDR_W  PC of the head entry
id_inst_o  out  INST_W  instruction of the head entry
count_o  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, count=0, read/write pointers=0.
  - rom_ce_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0.
  - Outputs reach these values immediately, with no clock required.
- Pop condition: pop = id_valid_o & id_ready_i & ~stall_i & ~branch_flag_i.
- Push condition: push = ~stall_i & ~branch_flag_i & ((count<DEPTH) | pop).
- rom_ce_o = push while rst=1. rom_ce_o depends combinationally on id_ready_i.
- On a push edge:
  - FIFO[wptr] <= {pc, rom_inst_i}.
  - pc <= pc+PC_STEP, wrapping modulo 2^ADDR_W.
  - wptr increments, wrapping modulo DEPTH.
- On a pop edge: rptr increments, wrapping modulo DEPTH.
- count update: +1 on push only, -1 on pop only, unchanged when push and pop coincide.
- A full FIFO with a pop in the same cycle still pushes; count stays at DEPTH.
- id_valid_o = (count!=0).
- id_pc_o and id_inst_o:
  - When count!=0, they show FIFO[rptr].
  - When count==0, both are forced to 0.
- Latency: an instruction fetched at edge N is presented to ID in cycle N+1. Steady throughput is 1 instruction per cycle when id_ready_i=1.
- Stall (stall_i=1, branch_flag_i=0): no push, no pop; pc, pointers, count and outputs hold.
- Branch (branch_flag_i=1, highest priority, overrides stall_i and id_ready_i):
  - At the edge: count<=0, rptr<=wptr<=0, pc<=branch_addr_i.
  - No push and no pop occur.
  - id_valid_o=0 in the following cycle.
  - The target instruction is fetched in that following cycle and becomes valid one cycle later.
- Back-pressure: with id_ready_i=0, the FIFO fills to DEPTH, then rom_ce_o=0 and pc holds at the next unfetched address.
- PC wrap: pc=2^ADDR_W-PC_STEP plus a push gives pc=0. There is no error flag.

Optional Feature:
IF_FETCH_BYPASS_EN
- Defined: when count==0, rom_ce_o=1 and id_ready_i=1, the ROM word bypasses the FIFO combinationally.
  - id_valid_o=1, id_pc_o=pc, id_inst_o=rom_inst_i.
  - The word is consumed directly, not written to the FIFO; count stays 0 and pc advances.
  - Fetch-to-ID latency becomes 0 cycles when the FIFO is empty.
- Undefined: no bypass; 1-cycle latency as specified above.

Test Plan:
1. Reset release, id_ready_i=1, ROM word = address^0xA5A5 -> id_pc_o = 0,1,2,3… one per cycle starting 1 cycle after the first fetch edge; id_inst_o matches; count_o stays 1.
2. id_ready_i=0 for 6 cycles after reset -> count_o rises 1..4 and saturates; rom_ce_o=0; rom_addr_o holds 4. Then id_ready_i=1 -> pops 0,1,2,3,4,5 back-to-back with no bubble.
3. count_o=3, branch_flag_i=1, branch_addr_i=0x0100 for 1 cycle -> next cycle count_o=0, id_valid_o=0, rom_addr_o=0x0100; the cycle after, id_pc_o=0x0100 then 0x0101.
4. count_o=2, stall_i=1 for 3 cycles with id_ready_i=1 -> rom_ce_o=0; pc, count_o, id_pc_o, id_inst_o unchanged; resumes normally when stall_i=0. Branch asserted during stall -> flush still occurs.
5. Branch to 0xFFFE with PC_STEP=1 -> fetched PCs 0xFFFE, 0xFFFF, 0x0000, 0x0001.
6. rst driven low mid-cycle with count_o=4 -> id_valid_o=0, count_o=0, rom_ce_o=0 immediately; after release, first fetch address equals RESET_PC. With IF_FETCH_BYPASS_EN defined, same bench plus id_ready_i=1 -> id_pc_o=RESET_PC in the first post-reset cycle.
